// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID (word 0) and
// build timestamp (word 1) from the sysid slave and compares them against the
// image constants. The captured words and the pass/fail/timeout status go to
// board-level logic.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h466D5D8C,
    parameter logic [31:0] EXPECTED_TS    = 32'h4E011D28,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
    } state_t;

    // Last count value a transaction may use before it is abandoned.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic        r_auto;
    logic        r_busy, r_done, r_id_ok, r_ts_ok, r_timeout;
    logic [31:0] r_id_value, r_ts_value;

    logic w_start, w_limit, w_in_xfer;
    logic w_accept, w_id_cap, w_ts_cap, w_tmo;

    // r_auto stands in for a start pulse on the first edge out of reset.
    assign w_start   = start | r_auto;
    assign w_limit   = (r_cnt == LIMIT);
    assign w_in_xfer = (r_state == S_ID_REQ) || (r_state == S_ID_WAIT) ||
                       (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // rather than in the sensitivity list; state uses <= so every register
        // sees the pre-edge values of its neighbours.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode plus one-cycle strobes that steer the datapath.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_id_cap     = 1'b0;
        w_ts_cap     = 1'b0;
        w_tmo        = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ID_REQ;
                end
            end
            S_ID_REQ: begin
                // Request acceptance is not completion, so the limit still aborts.
                if (w_limit) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_DONE;
                end else if (!avm_waitrequest) begin
                    w_state_next = S_ID_WAIT;
                end
            end
            S_ID_WAIT: begin
                // A response on the limit cycle completes the read.
                if (avm_readdatavalid) begin
                    w_id_cap     = 1'b1;
                    w_state_next = S_TS_REQ;
                end else if (w_limit) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_TS_REQ: begin
                if (w_limit) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_DONE;
                end else if (!avm_waitrequest) begin
                    w_state_next = S_TS_WAIT;
                end
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    w_ts_cap     = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_limit) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-transaction cycle counter, restarted on entry to each REQ state.
    always_ff @(posedge clk) begin
        if (!reset_n)                  r_cnt <= '0;
        else if (w_accept || w_id_cap) r_cnt <= '0;
        else if (w_in_xfer)            r_cnt <= r_cnt + 16'd1;
    end

    // Status flags and captured words.
    always_ff @(posedge clk) begin
        // NOTE: the captured words are plain registers, not storage arrays,
        // so they are cleared with the rest of the status.
        if (!reset_n) begin
            r_auto     <= AUTO_START;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_auto <= 1'b0;
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_id_cap) begin
                r_id_value <= avm_readdata;
                r_id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (w_ts_cap) begin
                r_ts_value <= avm_readdata;
                r_ts_ok    <= CHECK_TS ? (avm_readdata == EXPECTED_TS) : 1'b1;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
            end
            if (w_tmo) begin
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
            end
        end
    end

    // The read strobe comes straight from state, so it drops in WAIT, DONE and
    // right after reset.
    assign avm_read    = (r_state == S_ID_REQ) || (r_state == S_TS_REQ);
    assign avm_address = (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
